// File: rtl/dac8568_frame_writer.sv
// dac8568_frame_writer
//
// SPI frame generator for the DAC8568. Takes one {channel, code} word from a
// first-word-fall-through instruction queue and shifts out one 32-bit write
// frame MSB first. The DAC samples din on the falling edge of sclk. Also
// issues the one-shot internal-reference-enable frame (0x08000001) on request.
// A reference request has priority over queued data. A request seen while busy
// is remembered and serviced once, however many requests arrive meanwhile.
//
// Frame timing, with the acceptance edge at cycle T:
//   nsync low for T+1 .. T+64*CLK_DIV
//   GAP_CYC idle cycles, then one DONE cycle
//   DONE cycle pulses wr_done_out for data frames only
//   next word can be accepted in the cycle after DONE
//
// Parameters:
//   CHAN_W  channel index width (3 for the eight channels)
//   DATA_W  DAC code width; fixed at 16 by the device
//   CLK_DIV sclk half-period in clk_in cycles (>= 1)
//   GAP_CYC clk_in cycles nsync stays high after a frame (>= CLK_DIV+1)
//
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous active-high reset
//   dv_in       queue output valid; chan_in/data_in hold until wr_done_out
//   chan_in     target channel
//   data_in     unsigned DAC code
//   ref_set_in  request internal-reference-enable frame (level or pulse)
//   rdy_out     high while idle and able to accept
//   nsync_out   frame select, active low
//   sclk_out    serial clock, idles high
//   din_out     serial data, MSB first
//   nldac_out   load DAC, active low
//   nclr_out    clear, active low; released on the first edge after reset
//   wr_done_out one-cycle pulse ending a data frame (queue read strobe)
//
// Build option:
//   DAC_LDAC_SYNC_EN  data frames write the input register only. nldac_out
//                     idles high and pulses low for CLK_DIV cycles at the
//                     start of the gap after each data frame. When undefined,
//                     data frames write-and-update and nldac_out is held low.
module dac8568_frame_writer #(
  parameter int CHAN_W  = 3,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              dv_in,
  input  logic [CHAN_W-1:0] chan_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ref_set_in,
  output logic              rdy_out,
  output logic              nsync_out,
  output logic              sclk_out,
  output logic              din_out,
  output logic              nldac_out,
  output logic              nclr_out,
  output logic              wr_done_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [31:0] REF_FRAME = 32'h0800_0001;

`ifdef DAC_LDAC_SYNC_EN
  localparam logic [3:0]       DATA_CTRL  = 4'b0000;
  localparam logic             NLDAC_IDLE = 1'b1;
  localparam logic [GAP_W-1:0] LDAC_LAST  = GAP_W'(CLK_DIV - 1);
`else
  localparam logic [3:0]       DATA_CTRL  = 4'b0011;
  localparam logic             NLDAC_IDLE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state, state_n;
  logic [5:0]       half_cnt, half_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [31:0]      shreg, shreg_n;
  logic             is_ref, is_ref_n;
  logic             ref_pend, ref_pend_n;
  logic             nsync_n, sclk_n, din_n, nldac_n, wr_done_n, rdy_n;
  logic             load;
  logic [31:0]      load_word;
  logic [31:0]      data_frame;

  assign data_frame = {4'b0000, DATA_CTRL, 1'b0, chan_in, data_in, 4'b0000};

  always_comb begin
    state_n    = state;
    half_n     = half_cnt;
    div_n      = div_cnt;
    gap_n      = gap_cnt;
    shreg_n    = shreg;
    is_ref_n   = is_ref;
    ref_pend_n = ref_pend | ref_set_in;
    nsync_n    = nsync_out;
    sclk_n     = sclk_out;
    din_n      = din_out;
    nldac_n    = nldac_out;
    wr_done_n  = 1'b0;
    load       = 1'b0;
    load_word  = '0;

    case (state)
      IDLE: begin
        if (rdy_out) begin
          if (ref_set_in || ref_pend) begin
            load       = 1'b1;
            load_word  = REF_FRAME;
            is_ref_n   = 1'b1;
            ref_pend_n = 1'b0;
          end else if (dv_in) begin
            load      = 1'b1;
            load_word = data_frame;
            is_ref_n  = 1'b0;
          end
        end
      end

      // half_cnt counts sclk half-periods: even = high phase, odd = low phase
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (half_cnt == 6'd63) begin
            state_n = GAP;
            gap_n   = '0;
            nsync_n = 1'b1;
            sclk_n  = 1'b1;
            din_n   = 1'b0;
`ifdef DAC_LDAC_SYNC_EN
            if (!is_ref) nldac_n = 1'b0;
`endif
          end else begin
            half_n = half_cnt + 6'd1;
            if (!half_cnt[0]) begin
              sclk_n = 1'b0;
            end else begin
              // next bit is presented together with the rising sclk edge
              sclk_n  = 1'b1;
              din_n   = shreg[31];
              shreg_n = {shreg[30:0], 1'b0};
            end
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end

      GAP: begin
`ifdef DAC_LDAC_SYNC_EN
        if (gap_cnt == LDAC_LAST) nldac_n = 1'b1;
`endif
        if (gap_cnt == GAP_LAST) begin
          state_n   = DONE;
          wr_done_n = !is_ref;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase

    if (load) begin
      state_n = SHIFT;
      half_n  = '0;
      div_n   = '0;
      nsync_n = 1'b0;
      sclk_n  = 1'b1;
      din_n   = load_word[31];
      shreg_n = {load_word[30:0], 1'b0};
    end

    rdy_n = (state_n == IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      half_cnt    <= '0;
      div_cnt     <= '0;
      gap_cnt     <= '0;
      is_ref      <= 1'b0;
      ref_pend    <= 1'b0;
      nsync_out   <= 1'b1;
      sclk_out    <= 1'b1;
      din_out     <= 1'b0;
      nldac_out   <= NLDAC_IDLE;
      wr_done_out <= 1'b0;
      rdy_out     <= 1'b0;
      nclr_out    <= 1'b0;
    end else begin
      state       <= state_n;
      half_cnt    <= half_n;
      div_cnt     <= div_n;
      gap_cnt     <= gap_n;
      is_ref      <= is_ref_n;
      ref_pend    <= ref_pend_n;
      nsync_out   <= nsync_n;
      sclk_out    <= sclk_n;
      din_out     <= din_n;
      nldac_out   <= nldac_n;
      wr_done_out <= wr_done_n;
      rdy_out     <= rdy_n;
      nclr_out    <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    shreg <= shreg_n;
  end

endmodule

// File: tb/tb_dac8568_frame_writer.sv
// Testbench for dac8568_frame_writer: directed sequence with random words,
// frames captured from the serial pins and compared with a word-level model.
module tb_dac8568_frame_writer;

  localparam int CLK_DIV   = 2;
  localparam int GAP_CYC   = 4;
  localparam int FRAME_CYC = 64 * CLK_DIV;
  localparam int DONE_OFS  = FRAME_CYC + GAP_CYC;
  // gap, the DONE cycle and the IDLE acceptance cycle separate two frames
  localparam int HIGH_CYC  = GAP_CYC + 2;
  localparam int PERIOD    = FRAME_CYC + HIGH_CYC;
  localparam logic [31:0] REF_FRAME = 32'h0800_0001;
`ifdef DAC_LDAC_SYNC_EN
  localparam int   CTRL_EXP  = 0;
  localparam logic NLDAC_RST = 1'b1;
`else
  localparam int   CTRL_EXP  = 3;
  localparam logic NLDAC_RST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [2:0]  chan;
  logic [15:0] data;
  logic        ref_set;
  logic        rdy_out, nsync_out, sclk_out, din_out, nldac_out, nclr_out, wr_done_out;

  dac8568_frame_writer #(
    .CHAN_W(3), .DATA_W(16), .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk_in(clk), .rst_in(rst), .dv_in(dv), .chan_in(chan), .data_in(data),
    .ref_set_in(ref_set), .rdy_out(rdy_out), .nsync_out(nsync_out),
    .sclk_out(sclk_out), .din_out(din_out), .nldac_out(nldac_out),
    .nclr_out(nclr_out), .wr_done_out(wr_done_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] frameq[$];
  int bitq[$], lowq[$], fallq[$], riseq[$], doneq[$], nl_startq[$], nl_lenq[$];
  int sclk_bad = 0, din_bad = 0, idle_bad = 0, nldac_hi = 0;

  logic        prev_nsync = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0, prev_nldac = NLDAC_RST;
  logic [31:0] cap = '0;
  int          run = 0, low_len = 0, cur_bits = 0, nl_run = 0;

  // Word-level model of one data frame: control nibble, channel, code, padding.
  function automatic logic [31:0] model_frame(input logic [2:0] c, input logic [15:0] d);
    return 32'(CTRL_EXP) * 32'h0100_0000 + 32'(c) * 32'h0010_0000 + 32'(d) * 32'd16;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    frameq.delete(); bitq.delete(); lowq.delete(); fallq.delete();
    riseq.delete(); doneq.delete(); nl_startq.delete(); nl_lenq.delete();
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_done_out) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fall(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!nsync_out) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Pin monitor: rebuilds frames from sclk falling edges, measures timing.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_nsync = 1'b1; prev_sclk = 1'b1; prev_din = 1'b0; prev_nldac = NLDAC_RST;
        low_len = 0; cur_bits = 0; run = 0;
      end else begin
        if (nldac_out) nldac_hi++;
        if (!nldac_out && prev_nldac) begin
          nl_startq.push_back(cyc);
          nl_run = 1;
        end else if (!nldac_out) begin
          nl_run++;
        end else if (!prev_nldac) begin
          nl_lenq.push_back(nl_run);
        end
        if (wr_done_out) doneq.push_back(cyc);
        if (!nsync_out) begin
          if (prev_nsync) begin
            fallq.push_back(cyc);
            run = 1; cur_bits = 0; cap = '0; low_len = 1;
            if (!sclk_out) sclk_bad++;
          end else begin
            low_len++;
            if (din_out !== prev_din && !(sclk_out && !prev_sclk)) din_bad++;
            if (sclk_out == prev_sclk) begin
              run++;
            end else begin
              if (run != CLK_DIV) sclk_bad++;
              if (prev_sclk && !sclk_out) begin
                cap = {cap[30:0], din_out};
                cur_bits++;
              end
              run = 1;
            end
          end
        end else if (!prev_nsync) begin
          if (run != CLK_DIV) sclk_bad++;
          if (!sclk_out || din_out) idle_bad++;
          riseq.push_back(cyc);
          frameq.push_back(cap);
          bitq.push_back(cur_bits);
          lowq.push_back(low_len);
        end
        prev_nsync = nsync_out; prev_sclk = sclk_out; prev_din = din_out; prev_nldac = nldac_out;
      end
    end
  end

  initial begin
    bit          got;
    logic [2:0]  wc[4];
    logic [15:0] wd[4];
    logic [2:0]  c;
    logic [15:0] d;

    rst = 1'b1; dv = 1'b0; ref_set = 1'b0; chan = '0; data = '0;
    repeat (3) @(negedge clk);

    check("rst_nsync", 32'(nsync_out), 32'd1);
    check("rst_sclk", 32'(sclk_out), 32'd1);
    check("rst_din", 32'(din_out), 32'd0);
    check("rst_wr_done", 32'(wr_done_out), 32'd0);
    check("rst_rdy", 32'(rdy_out), 32'd0);
    check("rst_nclr", 32'(nclr_out), 32'd0);
    check("rst_nldac", 32'(nldac_out), 32'(NLDAC_RST));

    // Single data frame straight out of reset
    clear_q();
    chan = 3'd5; data = 16'hABCD; dv = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rdy_at_release", 32'(rdy_out), 32'd0);
    check("nclr_at_release", 32'(nclr_out), 32'd0);
    @(negedge clk);
    check("rdy_after_release", 32'(rdy_out), 32'd1);
    check("nclr_after_release", 32'(nclr_out), 32'd1);
    wait_done(400, got);
    check("t1_done_seen", 32'(got), 32'd1);
    dv = 1'b0;
    @(negedge clk);
    check("t1_rdy_idle", 32'(rdy_out), 32'd1);
    repeat (3) @(negedge clk);
    check("t1_nframes", 32'(frameq.size()), 32'd1);
    check("t1_frame", frameq[0], model_frame(3'd5, 16'hABCD));
    check("t1_bits", 32'(bitq[0]), 32'd32);
    check("t1_low_len", 32'(lowq[0]), 32'(FRAME_CYC));
    check("t1_ndone", 32'(doneq.size()), 32'd1);
    check("t1_done_ofs", 32'(doneq[0] - fallq[0]), 32'(DONE_OFS));

    // Reference request and data together: reference goes first
    clear_q();
    c = 3'($urandom_range(0, 7)); d = 16'($urandom);
    chan = c; data = d; dv = 1'b1; ref_set = 1'b1;
    @(negedge clk);
    ref_set = 1'b0;
    wait_done(800, got);
    check("t2_done_seen", 32'(got), 32'd1);
    dv = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_nframes", 32'(frameq.size()), 32'd2);
    check("t2_ref_frame", frameq[0], REF_FRAME);
    check("t2_data_frame", frameq[1], model_frame(c, d));
    check("t2_ndone", 32'(doneq.size()), 32'd1);
    check("t2_done_ofs", 32'(doneq[0] - fallq[1]), 32'(DONE_OFS));

    // Three reference requests during one data frame collapse to one
    clear_q();
    c = 3'($urandom_range(0, 7)); d = 16'($urandom);
    chan = c; data = d; dv = 1'b1;
    wait_fall(50, got);
    check("t3_fall_seen", 32'(got), 32'd1);
    for (int k = 0; k < 3; k++) begin
      repeat (10) @(negedge clk);
      ref_set = 1'b1;
      @(negedge clk);
      ref_set = 1'b0;
    end
    wait_done(400, got);
    check("t3_done_seen", 32'(got), 32'd1);
    dv = 1'b0;
    repeat (600) @(negedge clk);
    check("t3_nframes", 32'(frameq.size()), 32'd2);
    check("t3_data_frame", frameq[0], model_frame(c, d));
    check("t3_ref_frame", frameq[1], REF_FRAME);
    check("t3_ndone", 32'(doneq.size()), 32'd1);

    // Four queued words with dv held high
    clear_q();
    for (int i = 0; i < 4; i++) begin
      wc[i] = 3'($urandom_range(0, 7));
      wd[i] = 16'($urandom);
    end
    dv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chan = wc[i]; data = wd[i];
      wait_done(400, got);
      check("t4_done_seen", 32'(got), 32'd1);
    end
    dv = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_nframes", 32'(frameq.size()), 32'd4);
    check("t4_ndone", 32'(doneq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t4_frame", frameq[i], model_frame(wc[i], wd[i]));
      check("t4_done_ofs", 32'(doneq[i] - fallq[i]), 32'(DONE_OFS));
    end
    for (int i = 1; i < 4; i++) begin
      check("t4_high_gap", 32'(fallq[i] - riseq[i-1]), 32'(HIGH_CYC));
      check("t4_period", 32'(fallq[i] - fallq[i-1]), 32'(PERIOD));
    end

    // Reset in the middle of a frame; the same word is sent again afterwards
    clear_q();
    c = 3'($urandom_range(0, 7)); d = 16'($urandom);
    chan = c; data = d; dv = 1'b1;
    wait_fall(50, got);
    check("t5_fall_seen", 32'(got), 32'd1);
    repeat (21 * 2 * CLK_DIV) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_async_nsync", 32'(nsync_out), 32'd1);
    check("t5_async_sclk", 32'(sclk_out), 32'd1);
    check("t5_async_din", 32'(din_out), 32'd0);
    check("t5_async_rdy", 32'(rdy_out), 32'd0);
    check("t5_async_nclr", 32'(nclr_out), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_no_done", 32'(doneq.size()), 32'd0);
    check("t5_no_frame", 32'(frameq.size()), 32'd0);
    rst = 1'b0;
    wait_done(400, got);
    check("t5_done_seen", 32'(got), 32'd1);
    dv = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_nframes", 32'(frameq.size()), 32'd1);
    check("t5_frame", frameq[0], model_frame(c, d));
    check("t5_low_len", 32'(lowq[0]), 32'(FRAME_CYC));
    check("t5_ndone", 32'(doneq.size()), 32'd1);

    // Channel 2, code 0x0001, and the load-DAC line
    clear_q();
    chan = 3'd2; data = 16'h0001; dv = 1'b1;
    wait_done(400, got);
    check("t6_done_seen", 32'(got), 32'd1);
    dv = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_frame", frameq[0], model_frame(3'd2, 16'h0001));
`ifdef DAC_LDAC_SYNC_EN
    check("t6_nldac_pulses", 32'(nl_startq.size()), 32'd1);
    check("t6_nldac_start", 32'(nl_startq[0]), 32'(riseq[0]));
    check("t6_nldac_len", 32'(nl_lenq[0]), 32'(CLK_DIV));
    clear_q();
    ref_set = 1'b1;
    @(negedge clk);
    ref_set = 1'b0;
    repeat (300) @(negedge clk);
    check("t6_ref_frame", frameq[0], REF_FRAME);
    check("t6_ref_no_nldac", 32'(nl_startq.size()), 32'd0);
`else
    check("t6_nldac_low", 32'(nldac_out), 32'd0);
    check("t6_nldac_never_high", 32'(nldac_hi), 32'd0);
`endif

    check("sclk_phase_errors", 32'(sclk_bad), 32'd0);
    check("din_change_errors", 32'(din_bad), 32'd0);
    check("idle_level_errors", 32'(idle_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
